// File: rtl/axi_backing_memory.sv
// axi_backing_memory
//   AXI-style slave memory that serves cache line fills and write-backs from
//   an on-chip word array. One write burst and one read burst are handled at
//   a time. The read latency can be set from 0 to 15 cycles.
//
// Ports
//   clk, rst                    clock (rising edge) and async active-high reset
//   AW*  (VALID/READY/ID/LEN/ADDR) write address channel; word addresses
//   W*   (VALID/READY/LAST/ID/DATA) write data channel; WID is ignored
//   B*   (VALID/READY/ID)        write response
//   AR*  (VALID/READY/ID/LEN/ADDR) read address channel
//   R*   (VALID/READY/LAST/ID/DATA) read data channel
//   protocol_err                sticky: WLAST disagreed with the AWLEN beat count
//
// Address bits at and above DEPTH_LOG2 are ignored, so addresses alias and wrap.
// The array is not cleared by reset.
module axi_backing_memory #(
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_LOG2   = 14,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;

  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);
  localparam logic [3:0]            LAT     = 4'(READ_LATENCY);

  logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];

  wstate_t               r_wstate;
  logic [3:0]            r_awlen;
  logic [3:0]            r_wcnt;
  logic [DEPTH_LOG2-1:0] r_waddr;

  rstate_t               r_rstate;
  logic [3:0]            r_arlen;
  logic [3:0]            r_rbeat;
  logic [3:0]            r_rlat;
  logic [DEPTH_LOG2-1:0] r_raddr;

  logic w_wr_en;
  logic w_last_beat;
  logic w_unused;

  // Ready outputs are forced low during reset because the idle state
  // would otherwise advertise readiness while rst is high.
  // A write parked in W_RESP has already committed its data, so it does
  // not hold off a read; only an in-flight W_DATA burst does.
  assign AWREADY     = !rst && (r_wstate == W_IDLE);
  assign WREADY      = (r_wstate == W_DATA);
  assign ARREADY     = !rst && (r_rstate == R_IDLE) && (r_wstate != W_DATA) && !AWVALID;

  assign w_wr_en     = (r_wstate == W_DATA) && WVALID;
  assign w_last_beat = (r_wcnt == r_awlen);

  assign w_unused    = ^{WID, AWADDR[ADDR_WIDTH-1:DEPTH_LOG2], ARADDR[ADDR_WIDTH-1:DEPTH_LOG2]};

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_waddr] <= WDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate     <= W_IDLE;
      r_awlen      <= '0;
      r_wcnt       <= '0;
      r_waddr      <= '0;
      BVALID       <= 1'b0;
      BID          <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (AWVALID) begin
            r_awlen  <= AWLEN;
            r_waddr  <= AWADDR[DEPTH_LOG2-1:0];
            r_wcnt   <= '0;
            BID      <= AWID;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            // The beat count alone ends the burst; WLAST is only audited.
            if (WLAST != w_last_beat) protocol_err <= 1'b1;
            r_waddr <= r_waddr + ADDR_ONE;
            r_wcnt  <= r_wcnt + 4'd1;
            if (w_last_beat) begin
              BVALID   <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID   <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // r_raddr always points at the word to be fetched next, so the array
  // read for beat n+1 is issued on the handshake of beat n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_arlen  <= '0;
      r_rbeat  <= '0;
      r_rlat   <= '0;
      r_raddr  <= '0;
      RVALID   <= 1'b0;
      RLAST    <= 1'b0;
      RID      <= '0;
      RDATA    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          RVALID <= 1'b0;
          RLAST  <= 1'b0;
          if (ARVALID && ARREADY) begin
            RID      <= ARID;
            r_arlen  <= ARLEN;
            r_raddr  <= ARADDR[DEPTH_LOG2-1:0];
            r_rlat   <= LAT;
            r_rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rlat == 4'd0) begin
            RDATA    <= r_mem[r_raddr];
            r_raddr  <= r_raddr + ADDR_ONE;
            r_rbeat  <= '0;
            RVALID   <= 1'b1;
            RLAST    <= (r_arlen == 4'd0);
            r_rstate <= R_BURST;
          end else begin
            r_rlat <= r_rlat - 4'd1;
          end
        end
        R_BURST: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID   <= 1'b0;
              RLAST    <= 1'b0;
              r_rstate <= R_IDLE;
            end else begin
              RDATA   <= r_mem[r_raddr];
              r_raddr <= r_raddr + ADDR_ONE;
              r_rbeat <= r_rbeat + 4'd1;
              RLAST   <= ((r_rbeat + 4'd1) == r_arlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule
